// File: rtl/hnoc_pe_if.sv
// hnoc_pe_if: processing-element interface for a hierarchical NoC leaf port.
// The PE TX path is buffered into a small FIFO and presented to the leaf port
// as {dest, payload} flits. Flits from the leaf port addressed to MyAddr are
// buffered for the PE. All other flits are dropped and counted.
// Optional build macro: HNOC_PEIF_STATS_EN adds o_tx_cnt / o_rx_cnt transfer counters.

// Synchronous FIFO with registered ready/valid and a registered head word.
// The head register mirrors the oldest entry (first-word-fall-through).
module hnoc_pe_if_fifo #(
    parameter int Width = 32,
    parameter int Depth = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_req,
    input  logic [Width-1:0] push_data,
    output logic             push_ready,
    input  logic             pop_req,
    output logic [Width-1:0] pop_data,
    output logic             pop_valid
);
    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_r [Depth];
    logic [PtrW-1:0]  wr_ptr_r;
    logic [PtrW-1:0]  rd_ptr_r;
    logic [PtrW-1:0]  rd_ptr_next_s;
    logic [CntW-1:0]  count_r;
    logic [CntW-1:0]  count_next_s;
    logic [Width-1:0] head_r;
    logic [Width-1:0] head_next_s;
    logic             ready_r;
    logic             valid_r;
    logic             push_s;
    logic             pop_s;

    // Pointer advance with wrap at Depth (Depth need not be a power of two).
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        logic [PtrW-1:0] nxt;
        if (ptr == PtrW'(Depth - 1)) begin
            nxt = {PtrW{1'b0}};
        end else begin
            nxt = ptr + PtrW'(1);
        end
        return nxt;
    endfunction

    assign push_ready = ready_r;
    assign pop_valid  = valid_r;
    assign pop_data   = head_r;

    // Next occupancy, read pointer and head word from this cycle's handshakes.
    always_comb begin
        push_s = push_req & ready_r;
        pop_s  = pop_req & valid_r;

        if (push_s && !pop_s) begin
            count_next_s = count_r + CntW'(1);
        end else if (!push_s && pop_s) begin
            count_next_s = count_r - CntW'(1);
        end else begin
            count_next_s = count_r;
        end

        if (pop_s) begin
            rd_ptr_next_s = ptr_inc(rd_ptr_r);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        // The written word becomes the head when it lands on the next read slot.
        if (count_next_s == {CntW{1'b0}}) begin
            head_next_s = {Width{1'b0}};
        end else if (push_s && (wr_ptr_r == rd_ptr_next_s)) begin
            head_next_s = push_data;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Storage array; entries are only read after being written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers, occupancy and the registered ready/valid/head outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            count_r  <= {CntW{1'b0}};
            head_r   <= {Width{1'b0}};
            ready_r  <= 1'b0;
            valid_r  <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= ptr_inc(wr_ptr_r);
            end
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
            head_r   <= head_next_s;
            ready_r  <= (count_next_s != CntW'(Depth));
            valid_r  <= (count_next_s != {CntW{1'b0}});
        end
    end
endmodule

module hnoc_pe_if #(
    parameter int DataWidth = 36,
    parameter int AddrWidth = 4,
    parameter int MyAddr    = 0,
    parameter int TxDepth   = 2,
    parameter int RxDepth   = 4
) (
    input  logic                           i_sclk,
    input  logic                           i_reset,
    input  logic [DataWidth-AddrWidth-1:0] i_pe_data,
    input  logic [AddrWidth-1:0]           i_pe_dest,
    input  logic                           i_pe_valid,
    output logic                           o_pe_ready,
    output logic [DataWidth-1:0]           o_net_data,
    output logic                           o_net_data_valid,
    input  logic                           i_net_data_ready,
    input  logic [DataWidth-1:0]           i_net_data,
    input  logic                           i_net_data_valid,
    output logic                           o_net_data_ready,
    output logic [DataWidth-AddrWidth-1:0] o_pe_data,
    output logic                           o_pe_valid,
    input  logic                           i_pe_ready,
    output logic [7:0]                     o_misroute_cnt
`ifdef HNOC_PEIF_STATS_EN
    ,
    output logic [15:0]                    o_tx_cnt,
    output logic [15:0]                    o_rx_cnt
`endif
);
    localparam int PayW = DataWidth - AddrWidth;

    logic            is_local_s;
    logic            rx_ready_s;
    logic            drop_s;
    logic [7:0]      misroute_cnt_r;

    assign is_local_s       = (i_net_data[DataWidth-1 -: AddrWidth] == AddrWidth'(MyAddr));
    assign drop_s           = i_net_data_valid & rx_ready_s & ~is_local_s;
    assign o_net_data_ready = rx_ready_s;
    assign o_misroute_cnt   = misroute_cnt_r;

    // PE -> network: words are stored already formatted as {dest, payload};
    // a flit for MyAddr still goes out to the network.
    hnoc_pe_if_fifo #(
        .Width(DataWidth),
        .Depth(TxDepth)
    ) u_tx_fifo (
        .clk       (i_sclk),
        .rst_n     (i_reset),
        .push_req  (i_pe_valid),
        .push_data ({i_pe_dest, i_pe_data}),
        .push_ready(o_pe_ready),
        .pop_req   (i_net_data_ready),
        .pop_data  (o_net_data),
        .pop_valid (o_net_data_valid)
    );

    // Network -> PE: only flits addressed here are written; ready is not
    // gated by the address so misrouted flits are always consumed when not full.
    hnoc_pe_if_fifo #(
        .Width(PayW),
        .Depth(RxDepth)
    ) u_rx_fifo (
        .clk       (i_sclk),
        .rst_n     (i_reset),
        .push_req  (i_net_data_valid & is_local_s),
        .push_data (i_net_data[PayW-1:0]),
        .push_ready(rx_ready_s),
        .pop_req   (i_pe_ready),
        .pop_data  (o_pe_data),
        .pop_valid (o_pe_valid)
    );

    // Saturating count of flits dropped for carrying a foreign destination.
    always_ff @(posedge i_sclk or negedge i_reset) begin
        if (!i_reset) begin
            misroute_cnt_r <= 8'd0;
        end else if (drop_s && (misroute_cnt_r != 8'hFF)) begin
            misroute_cnt_r <= misroute_cnt_r + 8'd1;
        end else begin
            misroute_cnt_r <= misroute_cnt_r;
        end
    end

`ifdef HNOC_PEIF_STATS_EN
    logic [15:0] tx_cnt_r;
    logic [15:0] rx_cnt_r;

    assign o_tx_cnt = tx_cnt_r;
    assign o_rx_cnt = rx_cnt_r;

    // Wrapping counters of network-side TX transfers and PE-side RX deliveries.
    always_ff @(posedge i_sclk or negedge i_reset) begin
        if (!i_reset) begin
            tx_cnt_r <= 16'd0;
            rx_cnt_r <= 16'd0;
        end else begin
            if (o_net_data_valid && i_net_data_ready) begin
                tx_cnt_r <= tx_cnt_r + 16'd1;
            end else begin
                tx_cnt_r <= tx_cnt_r;
            end
            if (o_pe_valid && i_pe_ready) begin
                rx_cnt_r <= rx_cnt_r + 16'd1;
            end else begin
                rx_cnt_r <= rx_cnt_r;
            end
        end
    end
`else
    // Statistics counters are not present in this build.
`endif
endmodule

// File: doc/hnoc_pe_if.md
HNOC_PE_IF -- requirements
Module: hnoc_pe_if

Interface
REQ-001 SHALL have parameters: DataWidth, 36, total flit width; AddrWidth, 4, destination field width; MyAddr, 0, this PE's leaf address; TxDepth, 2, TX FIFO entries; RxDepth, 4, RX FIFO entries (power of 2, at least 2).
REQ-002 SHALL have these ports (name, direction, width, meaning):
- i_sclk, in, 1, sole clock, leaf-port clock domain.
- i_reset, in, 1, asynchronous active-low reset.
- i_pe_data, in, DataWidth-AddrWidth, PE TX payload.
- i_pe_dest, in, AddrWidth, PE TX destination.
- i_pe_valid, in, 1; o_pe_ready, out, 1: PE TX handshake.
- o_net_data, out, DataWidth; o_net_data_valid, out, 1; i_net_data_ready, in, 1: flit to leaf port.
- i_net_data, in, DataWidth; i_net_data_valid, in, 1; o_net_data_ready, out, 1: flit from leaf port.
- o_pe_data, out, DataWidth-AddrWidth; o_pe_valid, out, 1; i_pe_ready, in, 1: PE RX.
- o_misroute_cnt, out, 8, count of dropped misrouted flits.
REQ-003 SHALL use flit format: bits [DataWidth-1 -: AddrWidth] = destination, bits [DataWidth-AddrWidth-1:0] = payload.

Function
REQ-004 SHALL transfer on any valid/ready channel only in a cycle where both valid and ready are high at the i_sclk rising edge.
REQ-005 TX: o_pe_ready SHALL equal "TX FIFO not full".
REQ-006 TX: each accepted PE word SHALL be written as {i_pe_dest, i_pe_data}.
REQ-007 TX: o_net_data and o_net_data_valid SHALL be registered from the TX FIFO head. A word accepted in cycle N SHALL appear no earlier than N+1.
REQ-008 TX: destination MyAddr SHALL be sent to the network unchanged; there is no local loopback.
REQ-009 TX: o_net_data and o_net_data_valid SHALL hold stable while valid is high and i_net_data_ready is low.
REQ-010 RX: o_net_data_ready SHALL equal "RX FIFO not full"; there is no full-FIFO bypass.
REQ-011 RX: an accepted flit whose destination equals MyAddr SHALL write its payload into the RX FIFO.
REQ-012 RX: an accepted flit with any other destination SHALL be dropped, and o_misroute_cnt SHALL increment by 1, saturating at 255.
REQ-013 RX: o_pe_valid SHALL equal "RX FIFO not empty". o_pe_data SHALL show the head entry (first-word-fall-through). Write-to-valid latency SHALL be 1 cycle.
REQ-014 Both FIFOs SHALL support a simultaneous read and write in the same cycle. Occupancy then stays unchanged, and pointers wrap modulo depth.
REQ-015 Data SHALL be delivered in order on each path, with no loss except misroute drops.

Reset
REQ-016 While i_reset is low, all outputs SHALL be cleared immediately and held: valids 0, data 0, o_misroute_cnt 0, FIFOs empty, o_pe_ready 0, o_net_data_ready 0.
REQ-017 Ready outputs SHALL go high on the first i_sclk edge after i_reset deasserts.
REQ-018 A reset asserted mid-transfer SHALL discard all buffered flits; there is no partial delivery after reset.

Configuration
REQ-019 With macro HNOC_PEIF_STATS_EN defined, the block SHALL add outputs o_tx_cnt (16) and o_rx_cnt (16).
- o_tx_cnt counts network-side TX transfers.
- o_rx_cnt counts PE-side RX deliveries.
- Both wrap modulo 2^16 and reset to 0.
REQ-020 Without HNOC_PEIF_STATS_EN, those ports and their counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-021 PE sends payload 0x12345678, dest 3, i_net_data_ready=1 -> o_net_data=0x312345678, valid one cycle later, single beat.
REQ-022 i_net_data_ready=0, PE offers 3 words -> first 2 accepted, o_pe_ready=0 from then, o_net_data stable. Release ready -> both words out in order.
REQ-023 MyAddr=0, input flits 0x0AAAAAAAA then 0x5BBBBBBBB -> o_pe_data=0xAAAAAAAA delivered, second flit dropped, o_misroute_cnt=1.
REQ-024 i_pe_ready=0, 5 local flits offered -> 4 accepted, o_net_data_ready=0 on the 5th. One PE read -> 5th accepted next cycle, order preserved.
REQ-025 RX FIFO full, i_pe_ready=1 and local flit offered in the same cycle -> no write that cycle, ready rises next cycle. 256 misroutes -> counter holds 255.
REQ-026 i_reset pulsed low with 2 TX and 3 RX flits buffered -> all valids 0 immediately, no stale flit after release. With HNOC_PEIF_STATS_EN, counters read 0.
